// File: rtl/config_sequencer.sv
// -----------------------------------------------------------------------------
// config_sequencer
//
// Pauses tracing of a datapath, waits for it to drain, then streams a stored
// configuration image onto a byte-wide config bus, one unit at a time, and
// resumes tracing.
//
// Sequence: IDLE -> DRAIN -> (SEND x BYTES_PER_UNIT, GAP) x NUM_UNITS -> FIN -> IDLE
//
// Ports
//   clk, rst_n        single clock, asynchronous active-low reset
//   cfg_wr_en/unit/idx/data  host writes into the image buffer (only while idle)
//   start             request a reconfiguration (ignored while busy)
//   pipe_valid        OR of in-flight valid flags; only looked at in DRAIN
//   hold              stall upstream trace sources
//   tracing           enable tracing of all units (0 only in SEND/GAP)
//   configId          unit select on the config bus (IDLE_ID = nobody)
//   configData        config byte for the selected unit
//   busy              sequence in progress (DRAIN through FIN)
//   done              one-cycle pulse in the FIN cycle
//
// Handshake: there is no back-pressure on the config bus. A unit accepts a
// byte in every cycle where configId equals its id; start is a level sampled
// only in IDLE, and cfg_wr_en is a single-cycle strobe sampled only while
// busy=0.
//
// All outputs are registers: each transition loads the output values that
// belong to the state being entered, so outputs always describe state_q.
// -----------------------------------------------------------------------------
module config_sequencer #(
  parameter int          MAX_CHAINS     = 4,
  parameter int          NUM_UNITS      = 4,
  parameter int          BASE_ID        = 1,
  parameter logic [7:0]  IDLE_ID        = 8'hFF,
  parameter int          DRAIN_CYCLES   = 4,
  parameter int          BYTES_PER_UNIT = 3 * MAX_CHAINS,
  localparam int         UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1,
  localparam int         IW = (BYTES_PER_UNIT > 1) ? $clog2(BYTES_PER_UNIT) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_wr_en,
  input  logic [UW-1:0] cfg_wr_unit,
  input  logic [IW-1:0] cfg_wr_idx,
  input  logic [7:0]    cfg_wr_data,
  input  logic          start,
  input  logic          pipe_valid,
  output logic          hold,
  output logic          tracing,
  output logic [7:0]    configId,
  output logic [7:0]    configData,
  output logic          busy,
  output logic          done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DRAIN = 3'd1;
  localparam logic [2:0] S_SEND  = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(BYTES_PER_UNIT - 1);
  localparam logic [UW-1:0] UNIT_LAST  = UW'(NUM_UNITS - 1);

  logic [2:0]    state_q;
  logic [DW-1:0] drain_cnt_q;
  logic [UW-1:0] unit_q;
  logic [IW-1:0] idx_q;
  logic [7:0]    image_q [NUM_UNITS][BYTES_PER_UNIT];

  logic wr_ok;
  assign wr_ok = cfg_wr_en && !busy
              && (int'(cfg_wr_unit) < NUM_UNITS)
              && (int'(cfg_wr_idx) < BYTES_PER_UNIT);

  // Image buffer. Writes are blocked for the whole busy window (including
  // FIN) so the image cannot change underneath a sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int u = 0; u < NUM_UNITS; u++) begin
        for (int i = 0; i < BYTES_PER_UNIT; i++) begin
          image_q[u][i] <= 8'h00;
        end
      end
    end else if (wr_ok) begin
      image_q[cfg_wr_unit][cfg_wr_idx] <= cfg_wr_data;
    end
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      drain_cnt_q <= '0;
      unit_q      <= '0;
      idx_q       <= '0;
      tracing     <= 1'b1;
      hold        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      configId    <= IDLE_ID;
      configData  <= 8'h00;
    end else begin
      done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q     <= S_DRAIN;
            drain_cnt_q <= '0;
            hold        <= 1'b1;
            busy        <= 1'b1;
          end
        end

        // Count consecutive idle cycles; any valid flag restarts the count.
        S_DRAIN: begin
          if (pipe_valid) begin
            drain_cnt_q <= '0;
          end else if (drain_cnt_q == DRAIN_LAST) begin
            state_q    <= S_SEND;
            unit_q     <= '0;
            idx_q      <= '0;
            tracing    <= 1'b0;
            configId   <= 8'(BASE_ID);
            configData <= image_q[0][0];
          end else begin
            drain_cnt_q <= drain_cnt_q + DW'(1);
          end
        end

        S_SEND: begin
          if (idx_q == IDX_LAST) begin
            state_q    <= S_GAP;
            configId   <= IDLE_ID;
            configData <= 8'h00;
          end else begin
            idx_q      <= idx_q + IW'(1);
            configData <= image_q[unit_q][idx_q + IW'(1)];
          end
        end

        // One deselected cycle between units lets each unit reset its byte
        // counter before the next unit's stream begins.
        S_GAP: begin
          if (unit_q == UNIT_LAST) begin
            state_q <= S_FIN;
            tracing <= 1'b1;
            hold    <= 1'b0;
            done    <= 1'b1;
          end else begin
            state_q    <= S_SEND;
            unit_q     <= unit_q + UW'(1);
            idx_q      <= '0;
            configId   <= 8'(BASE_ID) + 8'(unit_q) + 8'd1;
            configData <= image_q[unit_q + UW'(1)][0];
          end
        end

        // start is deliberately not sampled here: a request in FIN is dropped.
        S_FIN: begin
          state_q <= S_IDLE;
          busy    <= 1'b0;
        end

        default: begin
          state_q    <= S_IDLE;
          tracing    <= 1'b1;
          hold       <= 1'b0;
          busy       <= 1'b0;
          configId   <= IDLE_ID;
          configData <= 8'h00;
        end
      endcase
    end
  end

endmodule
